// File: rtl/unidade_controle_pkg.sv
// Shared definitions for the sequence control unit: state codes, Moore output
// bundle with its decoder, and the default timeout.
package unidade_controle_pkg;

  localparam int TIMEOUT_CICLOS_PADRAO = 1000;

  typedef enum logic [3:0] {
    INICIAL     = 4'h0,
    PREPARACAO  = 4'h1,
    ESPERA      = 4'h2,
    REGISTRA    = 4'h3,
    COMPARA     = 4'h4,
    PROXIMO     = 4'h5,
    FIM_ACERTO  = 4'hA,
    FIM_TIMEOUT = 4'hD,
    FIM_ERRO    = 4'hE
  } estado_t;

  typedef struct packed {
    logic zera_n;
    logic conta;
    logic registra;
    logic pronto;
    logic acertou;
    logic errou;
    logic timeout;
  } saidas_t;

  // A 1-cycle timeout still needs a 1-bit counter.
  function automatic int largura(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // The counter is held (zera_n=1) in the end states so its final value stays visible.
  function automatic saidas_t decodifica(input estado_t e);
    saidas_t s;
    s        = '0;
    s.zera_n = 1'b1;
    case (e)
      INICIAL, PREPARACAO: s.zera_n = 1'b0;
      ESPERA, COMPARA:     ;
      REGISTRA:            s.registra = 1'b1;
      PROXIMO:             s.conta = 1'b1;
      FIM_ACERTO:          begin s.pronto = 1'b1; s.acertou = 1'b1; end
      FIM_ERRO:            begin s.pronto = 1'b1; s.errou = 1'b1; end
      FIM_TIMEOUT:         begin s.pronto = 1'b1; s.timeout = 1'b1; end
      default:             s.zera_n = 1'b0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/unidade_controle_sequencia_contador_timeout.sv
// Saturating up-counter used as the ESPERA timeout; fim flags the last allowed cycle.
module contador_timeout
  import unidade_controle_pkg::*;
#(
  parameter int MODULO = TIMEOUT_CICLOS_PADRAO
) (
  input  logic clock,
  input  logic reset_n,
  input  logic limpa,
  input  logic habilita,
  output logic fim
);

  localparam int W = largura(MODULO);
  localparam logic [W-1:0] ULTIMO = W'(MODULO - 1);

  logic [W-1:0] valor;

  // Saturates at the last value instead of wrapping.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valor <= '0;
    end else if (limpa) begin
      valor <= '0;
    end else if (habilita && (valor != ULTIMO)) begin
      valor <= valor + 1'b1;
    end
  end

  assign fim = (valor == ULTIMO);

endmodule

// File: rtl/unidade_controle_sequencia.sv
// Moore controller that walks a 74163-style position counter through a
// user-entered sequence, with a per-entry timeout.
//
// state       | meaning
// INICIAL     | idle, counter held clear
// PREPARACAO  | clear counter for a new sequence
// ESPERA      | wait for jogada, timer running
// REGISTRA    | load datapath input register
// COMPARA     | evaluate igual / fim
// PROXIMO     | advance position counter
// FIM_ACERTO  | whole sequence matched
// FIM_TIMEOUT | no jogada in time
// FIM_ERRO    | mismatch
module unidade_controle_sequencia
  import unidade_controle_pkg::*;
#(
  parameter int TIMEOUT_CICLOS = TIMEOUT_CICLOS_PADRAO
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       igual,
  input  logic       fim,
  output logic       zera_n,
  output logic       conta,
  output logic       registra,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic [3:0] db_estado
);

  estado_t estado;
  estado_t estado_prox;
  saidas_t saidas;
  logic    em_espera;
  logic    tempo_esgotado;

  assign em_espera = (estado == ESPERA);

  contador_timeout #(.MODULO(TIMEOUT_CICLOS)) u_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .limpa   (!em_espera),
    .habilita(em_espera),
    .fim     (tempo_esgotado)
  );

  always_comb begin
    estado_prox = INICIAL;
    case (estado)
      INICIAL:     estado_prox = iniciar ? PREPARACAO : INICIAL;
      PREPARACAO:  estado_prox = ESPERA;
      ESPERA: begin
        // A jogada in the last allowed cycle still counts.
        if (jogada)              estado_prox = REGISTRA;
        else if (tempo_esgotado) estado_prox = FIM_TIMEOUT;
        else                     estado_prox = ESPERA;
      end
      REGISTRA:    estado_prox = COMPARA;
      COMPARA: begin
        if (!igual)   estado_prox = FIM_ERRO;
        else if (fim) estado_prox = FIM_ACERTO;
        else          estado_prox = PROXIMO;
      end
      PROXIMO:     estado_prox = ESPERA;
      FIM_ACERTO,
      FIM_ERRO,
      FIM_TIMEOUT: estado_prox = iniciar ? PREPARACAO : estado;
      default:     estado_prox = INICIAL;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado <= INICIAL;
      saidas <= decodifica(INICIAL);
    end else begin
      estado <= estado_prox;
      saidas <= decodifica(estado_prox);
    end
  end

  assign zera_n    = saidas.zera_n;
  assign conta     = saidas.conta;
  assign registra  = saidas.registra;
  assign pronto    = saidas.pronto;
  assign acertou   = saidas.acertou;
  assign errou     = saidas.errou;
  assign timeout   = saidas.timeout;
  assign db_estado = estado;

endmodule
